mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port instruction/data memory between two requesters: instruction fetch (IF) and the load/store stage (LS) of the three-stage pipeline.
- Sequences each memory access: arbitrate, issue, wait a fixed latency, return the response.
- Only one transaction is outstanding at a time. LS has priority; a starvation guard forces an IF grant after a bounded run of LS grants.
- Supports an IF flush so that fetches on a wrong path are discarded after a taken branch.

Parameters:
- MEM_LAT, 2, memory read latency in cycles from the mem_en cycle to valid mem_rdata; legal range 1..15.
- MAX_LS_STREAK, 4, maximum number of consecutive LS grants while if_req is pending; legal range 1..15.

Ports:
- clk in 1: the single clock; all state updates on the rising edge.
- reset in 1: asynchronous, active-high reset.
- if_req in 1: fetch request; held high until if_gnt.
- if_addr in 32: fetch byte address; held stable until if_gnt.
- if_flush in 1: discard the in-flight IF response.
- if_gnt out 1: one-cycle pulse; the IF request has been accepted.
- if_rvalid out 1: one-cycle pulse; if_rdata is valid.
- if_rdata out 32: fetched instruction.
- ls_req in 1: load/store request; held high until ls_gnt.
- ls_we in 1: 1 = store, 0 = load.
- ls_addr in 32: load/store address.
- ls_wdata in 32: store data.
- ls_gnt out 1: one-cycle pulse; the LS request has been accepted.
- ls_rvalid out 1: one-cycle pulse; load data valid, or store complete.
- ls_rdata out 32: load data; 0 for stores.
- mem_en out 1: memory access strobe.
- mem_we out 1: memory write enable.
- mem_addr out 32: memory address.
- mem_wdata out 32: memory write data.
- mem_rdata in 32: memory read data, valid MEM_LAT cycles after mem_en.

Behaviour:
- Reset (asynchronous, at any time, including mid-transaction):
  - state goes to IDLE; all outputs and internal registers go to 0; streak counter and latency counter go to 0.
  - Any in-flight transaction is dropped, with no rvalid.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Arbitrate among the requests sampled this cycle.
  - The winner's owner bit, address, we and wdata are registered, and the FSM moves to ISSUE.
  - If there is no request, stay in IDLE.
- Arbitration:
  - Only ls_req: LS wins.
  - Only if_req: IF wins.
  - Both asserted: LS wins, unless streak == MAX_LS_STREAK, in which case IF wins.
- Streak counter:
  - Increments on an LS win while if_req=1, saturating at MAX_LS_STREAK.
  - Clears on an IF win, and on an LS win while if_req=0.
- ISSUE (exactly 1 cycle):
  - mem_en=1; mem_we = latched we for LS and 0 for IF; mem_addr and mem_wdata driven from the latched fields.
  - The owner's gnt pulses in this cycle; the requester may change its fields from the next cycle.
  - Latency counter loads MEM_LAT; next state is WAIT.
- WAIT:
  - mem_en=0; the latency counter decrements each cycle.
  - In the cycle the counter equals 1, mem_rdata is registered into the owner's rdata register, and the next state is RESP.
  - The IF response therefore pulses exactly MEM_LAT+1 cycles after the ISSUE cycle.
- RESP (1 cycle):
  - The owner's rvalid=1 with registered rdata. For a store, rvalid still pulses as the completion ack and ls_rdata=0.
  - Next state is IDLE.
- Outside RESP: rvalid=0, and rdata holds its last value.
- Throughput: one transaction every MEM_LAT+3 cycles.
- if_flush:
  - Asserted in any cycle from ISSUE through RESP of an IF-owned transaction, it sets a kill flag.
  - When the kill flag is set, if_rvalid is suppressed in RESP; the memory access still completes and the FSM timing is unchanged.
  - The kill flag clears on entry to IDLE.
  - if_flush has no effect on LS transactions or in IDLE.
- Grant and response signals are mutually exclusive: if_gnt and ls_gnt are never high together, nor are if_rvalid and ls_rvalid.
- A request deasserted before its gnt has undefined results; the bench asserts the requester protocol.

Decomposition:
- Shared package mem_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP);
  - the owner encoding (OWN_IF=0, OWN_LS=1);
  - the width constants XLEN=32 and CNT_W=4.
- No sub-module is needed; the arbitration and streak logic stays inline.

Test Plan:
1. Fetch, MEM_LAT=2: if_req=1, if_addr=0x100, memory returns 0x00500093 → if_gnt at cycle t+1, mem_en=1 with mem_addr=0x100 at t+1, if_rvalid with 0x00500093 at t+4, IDLE at t+5.
2. Simultaneous requests: if_req and ls_req (load, 0x2000) both asserted in the same IDLE cycle → ls_gnt first, ls_rvalid returns data; IF is granted in the next IDLE cycle.
3. Starvation guard, MAX_LS_STREAK=4: ls_req held high continuously with if_req high → exactly 4 LS grants, then 1 IF grant, then LS again; streak counter is 0 after the IF grant.
4. Store: ls_we=1, ls_addr=0x40, ls_wdata=0xDEADBEEF → mem_we=1 and mem_wdata=0xDEADBEEF in ISSUE, ls_rvalid pulses with ls_rdata=0, if_rvalid stays 0.
5. Flush: if_flush pulsed in WAIT of an IF transaction → no if_rvalid, FSM reaches IDLE on schedule, and the next fetch returns normally.
6. Reset mid-WAIT: reset asserted asynchronously → all outputs 0 immediately; after release, IDLE with no stale rvalid; a new request then completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and width constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store, one
// transaction outstanding, LS priority with a bounded-streak guard for IF.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT       = 2,
    parameter int MAX_LS_STREAK = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    input  logic            if_flush,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [XLEN-1:0] if_rdata,
    input  logic            ls_req,
    input  logic            ls_we,
    input  logic [XLEN-1:0] ls_addr,
    input  logic [XLEN-1:0] ls_wdata,
    output logic            ls_gnt,
    output logic            ls_rvalid,
    output logic [XLEN-1:0] ls_rdata,
    output logic            mem_en,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] LAT_INIT   = CNT_W'(MEM_LAT);
    localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_LS_STREAK);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_e           state_q;
    state_e           state_d;
    owner_e           owner_q;
    logic             we_q;
    logic             kill_q;
    logic [XLEN-1:0]  addr_q;
    logic [XLEN-1:0]  wdata_q;
    logic [XLEN-1:0]  if_rdata_q;
    logic [XLEN-1:0]  ls_rdata_q;
    logic [CNT_W-1:0] lat_cnt_q;
    logic [CNT_W-1:0] streak_q;

    logic any_req;
    logic ls_win;
    logic flush_hit;

    // LS wins unless IF has already waited through a full streak of LS grants.
    assign any_req   = if_req | ls_req;
    assign ls_win    = ls_req & ~(if_req & (streak_q == STREAK_MAX));
    assign flush_hit = if_flush & (owner_q == OWN_IF);

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        if_gnt    = 1'b0;
        ls_gnt    = 1'b0;
        if_rvalid = 1'b0;
        ls_rvalid = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                mem_en  = 1'b1;
                mem_we  = (owner_q == OWN_LS) & we_q;
                if_gnt  = (owner_q == OWN_IF);
                ls_gnt  = (owner_q == OWN_LS);
                state_d = WAIT;
            end
            WAIT: begin
                if (lat_cnt_q == CNT_ONE) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                // A flush arriving in the response cycle itself must still kill it.
                if_rvalid = (owner_q == OWN_IF) & ~kill_q & ~if_flush;
                ls_rvalid = (owner_q == OWN_LS);
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q    <= OWN_IF;
            we_q       <= 1'b0;
            kill_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
            lat_cnt_q  <= '0;
            streak_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    kill_q <= 1'b0;
                    if (any_req) begin
                        owner_q <= ls_win ? OWN_LS : OWN_IF;
                        addr_q  <= ls_win ? ls_addr : if_addr;
                        we_q    <= ls_win & ls_we;
                        wdata_q <= ls_win ? ls_wdata : '0;
                        if (ls_win && if_req) begin
                            streak_q <= (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;
                        end else begin
                            streak_q <= '0;
                        end
                    end
                end
                ISSUE: begin
                    lat_cnt_q <= LAT_INIT;
                    if (flush_hit) begin
                        kill_q <= 1'b1;
                    end
                end
                WAIT: begin
                    lat_cnt_q <= lat_cnt_q - 1'b1;
                    if (flush_hit) begin
                        kill_q <= 1'b1;
                    end
                    // Last wait cycle: memory data is valid now, capture for the owner.
                    if (lat_cnt_q == CNT_ONE) begin
                        if (owner_q == OWN_IF) begin
                            if_rdata_q <= mem_rdata;
                        end else begin
                            ls_rdata_q <= we_q ? '0 : mem_rdata;
                        end
                    end
                end
                RESP: begin
                    kill_q <= 1'b0;
                end
                default: begin
                    kill_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bench for mem_port_arbiter with a transaction-level
// reference model (arbitration rule, streak count, and a memory image).
module tb_mem_port_arbiter;

    localparam int MEM_LAT       = 2;
    localparam int MAX_LS_STREAK = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [31:0] dmem  [logic [31:0]];
    logic [31:0] rmem  [logic [31:0]];
    logic [31:0] sched [int];

    int streak_m;
    bit pend_if;
    bit pend_ls;

    mem_port_arbiter #(
        .MEM_LAT       (MEM_LAT),
        .MAX_LS_STREAK (MAX_LS_STREAK)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_gnt    (ls_gnt),
        .ls_rvalid (ls_rvalid),
        .ls_rdata  (ls_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = 32'h40 + (32'($urandom_range(0, 7)) << 2);
        return a;
    endfunction

    // Memory device: reads come back exactly MEM_LAT cycles after mem_en, noise otherwise.
    always @(negedge clk) begin
        if (mem_en) begin
            if (mem_we) dmem[mem_addr] = mem_wdata;
            else sched[cyc + MEM_LAT] = dmem.exists(mem_addr) ? dmem[mem_addr] : init_word(mem_addr);
        end
    end

    always @(posedge clk) begin
        #1;
        mem_rdata = sched.exists(cyc) ? sched[cyc] : $urandom;
    end

    always @(negedge clk) begin
        checks++;
        assert ({if_gnt & ls_gnt, if_rvalid & ls_rvalid} === 2'b00)
        else begin
            failures++;
            $error("FAIL exclusive observed gnt=%b%b rvalid=%b%b required no overlap",
                   if_gnt, ls_gnt, if_rvalid, ls_rvalid);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req_if(input logic [31:0] a);
        pend_if = 1'b1;
        if_req  = 1'b1;
        if_addr = a;
    endtask

    task automatic req_ls(input bit we, input logic [31:0] a, input logic [31:0] d);
        pend_ls  = 1'b1;
        ls_req   = 1'b1;
        ls_we    = we;
        ls_addr  = a;
        ls_wdata = d;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {26'd0, if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_en, mem_we}, 32'd0);
        chk({tag, "_addr"}, mem_addr, 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_if_rdata"}, if_rdata, 32'd0);
        chk({tag, "_ls_rdata"}, ls_rdata, 32'd0);
    endtask

    // Entered one step after the edge opening an idle cycle with requests driven.
    // flush_off: -1 none, -2 flush in the idle cycle, k flush k cycles after the grant.
    task automatic round(input int flush_off, output bit won_ls);
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_d;
        bit          we;
        bit          kill;
        won_ls = pend_ls && !(pend_if && streak_m == MAX_LS_STREAK);
        if (won_ls && pend_if) streak_m = (streak_m < MAX_LS_STREAK) ? streak_m + 1 : MAX_LS_STREAK;
        else streak_m = 0;
        a  = won_ls ? ls_addr : if_addr;
        we = won_ls && ls_we;
        wd = ls_wdata;
        if (we) begin
            rmem[a] = wd;
            exp_d   = 32'd0;
        end else begin
            exp_d = rmem.exists(a) ? rmem[a] : init_word(a);
        end
        kill     = !won_ls && flush_off >= 0 && flush_off <= MEM_LAT + 1;
        if_flush = (flush_off == -2);
        look();
        chk("idle_gnt", {30'd0, if_gnt, ls_gnt}, 32'd0);
        chk("idle_mem_en", {31'd0, mem_en}, 32'd0);
        tick();
        if_flush = (flush_off == 0);
        look();
        chk("gnt", {30'd0, if_gnt, ls_gnt}, {30'd0, !won_ls, won_ls});
        chk("mem_en", {31'd0, mem_en}, 32'd1);
        chk("mem_we", {31'd0, mem_we}, {31'd0, we});
        chk("mem_addr", mem_addr, a);
        if (we) chk("mem_wdata", mem_wdata, wd);
        for (int off = 1; off <= MEM_LAT + 1; off++) begin
            tick();
            if_flush = (flush_off == off);
            if (off == 1) begin
                if (won_ls) begin
                    pend_ls  = 1'b0;
                    ls_req   = 1'b0;
                    ls_we    = 1'($urandom);
                    ls_addr  = $urandom;
                    ls_wdata = $urandom;
                end else begin
                    pend_if = 1'b0;
                    if_req  = 1'b0;
                    if_addr = $urandom;
                end
            end
            look();
            if (off <= MEM_LAT) begin
                chk("wait_quiet", {29'd0, if_rvalid, ls_rvalid, mem_en}, 32'd0);
            end else begin
                chk("rvalid", {30'd0, if_rvalid, ls_rvalid}, {30'd0, !won_ls && !kill, won_ls});
                if (won_ls) chk("ls_rdata", ls_rdata, exp_d);
                else if (!kill) chk("if_rdata", if_rdata, exp_d);
            end
        end
        tick();
        if_flush = 1'b0;
    endtask

    initial begin
        bit       w1;
        bit       w2;
        bit [9:0] seq;
        int       fo;
        int       flush_off;

        reset    = 1'b1;
        if_req   = 1'b0;
        if_addr  = 32'd0;
        if_flush = 1'b0;
        ls_req   = 1'b0;
        ls_we    = 1'b0;
        ls_addr  = 32'd0;
        ls_wdata = 32'd0;
        streak_m = 0;
        pend_if  = 1'b0;
        pend_ls  = 1'b0;
        rmem[32'h100] = 32'h0050_0093;
        dmem[32'h100] = 32'h0050_0093;

        repeat (3) tick();
        look();
        chk_all_zero("reset");
        tick();
        reset = 1'b0;

        // Plain fetch.
        req_if(32'h100);
        round(-1, w1);
        chk("t1_owner", {31'd0, w1}, 32'd0);
        chk("t1_rdata_hold", if_rdata, 32'h0050_0093);

        // Simultaneous requests: LS first, IF on the following arbitration.
        req_if(32'h104);
        req_ls(1'b0, 32'h2000, 32'd0);
        round(-1, w1);
        round(-1, w2);
        chk("t2_order", {30'd0, w1, w2}, 32'd2);

        // Store then load back.
        req_ls(1'b1, 32'h40, 32'hDEAD_BEEF);
        round(-1, w1);
        chk("t4_store_rdata", ls_rdata, 32'd0);
        req_ls(1'b0, 32'h40, 32'd0);
        round(-1, w1);
        chk("t4_load", ls_rdata, 32'hDEAD_BEEF);

        // Flush during wait drops the response; the next fetch is normal.
        req_if(32'h108);
        round(1, w1);
        req_if(32'h100);
        round(-1, w1);
        chk("t5_next_fetch", if_rdata, 32'h0050_0093);

        // Starvation guard with LS requesting continuously.
        seq = '0;
        for (int i = 0; i < 10; i++) begin
            if (!pend_ls) req_ls(1'b0, rand_addr(), 32'd0);
            if (!pend_if) req_if(rand_addr());
            round(-1, w1);
            seq[9-i] = w1;
        end
        chk("t3_grant_seq", {22'd0, seq}, 32'h3DE);
        round(-1, w1);
        chk("t3_drain", {31'd0, w1}, 32'd1);

        // Asynchronous reset in the middle of a wait.
        if_req  = 1'b1;
        if_addr = 32'h200;
        tick();
        tick();
        if_req = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("reset_mid");
        repeat (2) tick();
        reset    = 1'b0;
        streak_m = 0;
        pend_if  = 1'b0;
        pend_ls  = 1'b0;
        for (int i = 0; i < MEM_LAT + 3; i++) begin
            look();
            chk("post_reset_quiet", {28'd0, if_gnt, ls_gnt, if_rvalid, ls_rvalid}, 32'd0);
            tick();
        end
        req_if(32'h100);
        round(-1, w1);
        chk("t6_after_reset", if_rdata, 32'h0050_0093);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            if (!pend_if && $urandom_range(0, 1) == 1) req_if(rand_addr());
            if (!pend_ls && $urandom_range(0, 2) != 0) req_ls(1'($urandom_range(0, 1)), rand_addr(), $urandom);
            if (!pend_if && !pend_ls) req_if(rand_addr());
            fo = int'($urandom_range(0, 7));
            if (fo <= MEM_LAT + 1) flush_off = fo;
            else if (fo == MEM_LAT + 2) flush_off = -2;
            else flush_off = -1;
            round(flush_off, w1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
